// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scan driver and debouncer for a 4x4 matrix keypad.
// Ports: clock, rst_n, row_in, col_out, col_idx, key_code/valid/ready, key_overrun.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] col_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_overrun
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_N = DW'(DEBOUNCE);
  localparam logic DB_ONE = (DEBOUNCE == 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HELD
  } state_t;

  state_t state, state_n;

  logic [3:0]    row_s1, rs;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    pat;
  logic [DW-1:0] match_cnt, rel_cnt;
  logic [DW-1:0] match_inc, rel_inc;

  logic [3:0] low, low_sel;
  logic       one_low, is_idle, match;
  logic [1:0] row_ix;
  logic [3:0] code_n;

  logic accept, col_adv;

  function automatic logic [3:0] col_dec(input logic [1:0] i);
    logic [3:0] c;
    unique case (i)
      2'd0: c = 4'b1110;
      2'd1: c = 4'b1101;
      2'd2: c = 4'b1011;
      2'd3: c = 4'b0111;
    endcase
    return c;
  endfunction

  // rows are asynchronous to clock
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_s1 <= row_in;
      rs     <= row_s1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

  // row decode; only a lone low bit names a key
  assign low     = ~rs;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign is_idle = (rs == 4'hF);
  assign match   = (rs == pat);
  assign low_sel = one_low ? low : 4'b0001;

  always_comb begin
    row_ix = 2'd0;
    unique case (1'b1)
      low_sel[0]: row_ix = 2'd0;
      low_sel[1]: row_ix = 2'd1;
      low_sel[2]: row_ix = 2'd2;
      low_sel[3]: row_ix = 2'd3;
      default:    row_ix = 2'd0;
    endcase
  end

  // (4*r + c + 1) mod 16
  assign code_n = {row_ix, col_idx} + 4'd1;

  assign match_inc = match_cnt + DW'(1);
  assign rel_inc   = rel_cnt + DW'(1);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (tick) begin
      unique case (state)
        S_SCAN: begin
          if (one_low) begin
            state_n = DB_ONE ? S_HELD : S_DEB;
          end
        end
        S_DEB: begin
          if (!match) begin
            state_n = S_SCAN;
          end else if (match_inc == DB_N) begin
            state_n = S_HELD;
          end
        end
        S_HELD: begin
          if (is_idle && rel_inc == DB_N) begin
            state_n = S_SCAN;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
  end

  always_comb begin
    accept  = 1'b0;
    col_adv = 1'b0;
    if (tick) begin
      unique case (state)
        S_SCAN: begin
          accept  = one_low && DB_ONE;
          col_adv = !one_low;
        end
        S_DEB: begin
          accept  = match && (match_inc == DB_N);
          col_adv = !match;
        end
        S_HELD: begin
          col_adv = is_idle && (rel_inc == DB_N);
        end
        default: begin
          accept  = 1'b0;
          col_adv = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= 4'hF;
      match_cnt <= '0;
      rel_cnt   <= '0;
    end else if (tick) begin
      unique case (state)
        S_SCAN: begin
          if (one_low) begin
            pat       <= rs;
            match_cnt <= DW'(1);
            rel_cnt   <= '0;
          end
        end
        S_DEB: begin
          if (match) begin
            match_cnt <= match_inc;
          end
          rel_cnt <= '0;
        end
        S_HELD: begin
          rel_cnt <= is_idle ? rel_inc : '0;
        end
        default: begin
          rel_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= 2'd0;
      col_out <= 4'b1110;
    end else if (col_adv) begin
      col_idx <= col_idx + 2'd1;
      col_out <= col_dec(col_idx + 2'd1);
    end
  end

  // a pending key is never overwritten unless it is taken this cycle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= code_n;
          key_valid <= 1'b1;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
